// File: rtl/sar_pkg.sv
// Shared constants and state encoding for the 4-bit successive-approximation search.
package sar_pkg;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned BIT_W = 2;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TEST = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sar_settle_timer.sv
// Settle counter: expired is high on the cycle the comparator flags may be sampled.
module sar_settle_timer
  import sar_pkg::*;
#(
  parameter int unsigned CMP_LAT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == CNT_W'(CMP_LAT));

endmodule

// File: rtl/sar_search_4_bits.sv
// 4-bit SAR search controller driving a magnitude comparator.
// Define SAR_ONEHOT_CHECK_EN to add the flag-integrity check and the err port.
module sar_search_4_bits
  import sar_pkg::*;
#(
  parameter int unsigned CMP_LAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cmp_e,
  input  logic             cmp_plus,
  input  logic             cmp_less,
  output logic [WIDTH-1:0] trial,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
`ifdef SAR_ONEHOT_CHECK_EN
  ,
  output logic             err
`endif
);

  state_t             state, state_nxt;
  logic [BIT_W-1:0]   bit_idx, bit_nxt;
  logic [WIDTH-1:0]   trial_nxt, result_nxt, upd;
  logic               busy_nxt, done_nxt;
  logic               expired, start_acc, sample, bad;
`ifdef SAR_ONEHOT_CHECK_EN
  logic               err_nxt;
`endif

  assign start_acc = (state == IDLE) && start;
  assign sample    = (state == TEST) && expired;

  sar_settle_timer #(
    .CMP_LAT (CMP_LAT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (start_acc || sample),
    .en      (state == TEST),
    .expired (expired)
  );

  // Next-state and datapath decisions; flags resolve e > less > plus.
  always_comb begin
    state_nxt  = state;
    bit_nxt    = bit_idx;
    trial_nxt  = trial;
    result_nxt = result;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    upd        = trial;
    bad        = 1'b0;
`ifdef SAR_ONEHOT_CHECK_EN
    err_nxt    = err;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = TEST;
          trial_nxt = {1'b1, {(WIDTH-1){1'b0}}};
          bit_nxt   = BIT_W'(WIDTH-1);
          busy_nxt  = 1'b1;
`ifdef SAR_ONEHOT_CHECK_EN
          err_nxt   = 1'b0;
`endif
        end
      end
      TEST: begin
        if (sample) begin
`ifdef SAR_ONEHOT_CHECK_EN
          bad = ((2'(cmp_e) + 2'(cmp_plus) + 2'(cmp_less)) != 2'd1);
`endif
          if (bad) begin
            result_nxt = '0;
`ifdef SAR_ONEHOT_CHECK_EN
            err_nxt    = 1'b1;
`endif
            state_nxt  = DONE;
            busy_nxt   = 1'b0;
            done_nxt   = 1'b1;
          end else if (cmp_e) begin
            result_nxt = trial;
            state_nxt  = DONE;
            busy_nxt   = 1'b0;
            done_nxt   = 1'b1;
          end else begin
            if (cmp_less) begin
              upd[bit_idx] = 1'b0;
            end
            if (bit_idx == '0) begin
              trial_nxt  = upd;
              result_nxt = upd;
              state_nxt  = DONE;
              busy_nxt   = 1'b0;
              done_nxt   = 1'b1;
            end else begin
              upd[bit_idx - BIT_W'(1)] = 1'b1;
              trial_nxt = upd;
              bit_nxt   = bit_idx - BIT_W'(1);
            end
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_idx <= '0;
      trial   <= '0;
      result  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SAR_ONEHOT_CHECK_EN
      err     <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      bit_idx <= bit_nxt;
      trial   <= trial_nxt;
      result  <= result_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
`ifdef SAR_ONEHOT_CHECK_EN
      err     <= err_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_sar_search_4_bits.sv
// Bench for sar_search_4_bits: behavioural comparators, bit-by-bit search model, directed cases.
module tb_sar_search_4_bits;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] tgt0, tgt2;
  logic       start0, start2;
  logic       force_en;
  logic [2:0] force_flags;
  logic       e0, p0, l0, e2, p2, l2;
  logic [3:0] trial0, result0, trial2, result2;
  logic       busy0, done0, busy2, done2;
`ifdef SAR_ONEHOT_CHECK_EN
  logic       err0, err2;
`endif

  int errors = 0;
  int checks = 0;
  logic [3:0] prev_res [2];
  logic [3:0] tlog [16];
  int         done_seen;

  always #5 clk = ~clk;

  // Behavioural magnitude comparators; flags on dut0 can be overridden.
  always_comb begin
    if (force_en) {e0, p0, l0} = force_flags;
    else begin
      e0 = (tgt0 == trial0);
      p0 = (tgt0 > trial0);
      l0 = (tgt0 < trial0);
    end
    e2 = (tgt2 == trial2);
    p2 = (tgt2 > trial2);
    l2 = (tgt2 < trial2);
  end

  sar_search_4_bits #(.CMP_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .cmp_e(e0), .cmp_plus(p0), .cmp_less(l0),
    .trial(trial0), .result(result0), .busy(busy0), .done(done0)
`ifdef SAR_ONEHOT_CHECK_EN
    , .err(err0)
`endif
  );

  sar_search_4_bits #(.CMP_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .cmp_e(e2), .cmp_plus(p2), .cmp_less(l2),
    .trial(trial2), .result(result2), .busy(busy2), .done(done2)
`ifdef SAR_ONEHOT_CHECK_EN
    , .err(err2)
`endif
  );

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Search by interval halving on the integer value of A.
  function automatic void model(input logic [3:0] a, output logic [3:0][3:0] tr,
                                output int n, output logic [3:0] fin);
    logic [3:0] prefix = 4'd0;
    logic [3:0] one = 4'b0001;
    logic [3:0] t;
    bit found = 1'b0;
    tr = '0;
    n = 4;
    fin = 4'd0;
    for (int s = 0; s < 4; s++) begin
      if (!found) begin
        t = prefix | (one << (3 - s));
        tr[s] = t;
        if (t == a) begin
          found = 1'b1;
          n = s + 1;
          fin = t;
        end else if (a > t) begin
          prefix = t;
        end
      end
    end
    if (!found) fin = prefix;
  endfunction

  task automatic set_start(input bit sel, input logic v);
    if (sel) start2 = v;
    else start0 = v;
  endtask

  // Start a search and compare every cycle through one idle cycle after done.
  task automatic run_search(input logic [3:0] a, input int lat, input bit sel, input int extra);
    logic [3:0][3:0] tr;
    logic [3:0] fin, t, r;
    logic b, d;
    int n, dc;
    model(a, tr, n, fin);
    dc = n * (lat + 1);
    @(negedge clk);
    if (sel) tgt2 = a;
    else tgt0 = a;
    set_start(sel, 1'b1);
    @(posedge clk); #1;
    set_start(sel, 1'b0);
    done_seen = -1;
    for (int c = 0; c <= dc + 1; c++) begin
      t = sel ? trial2 : trial0;
      r = sel ? result2 : result0;
      b = sel ? busy2 : busy0;
      d = sel ? done2 : done0;
      if (c < 16) tlog[c] = t;
      if (d && done_seen < 0) done_seen = c;
      chk($sformatf("busy a=%h c=%0d", a, c), 4'(b), 4'(c < dc));
      chk($sformatf("done a=%h c=%0d", a, c), 4'(d), 4'(c == dc));
      chk($sformatf("trial a=%h c=%0d", a, c), t, (c < dc) ? tr[c / (lat + 1)] : fin);
      chk($sformatf("result a=%h c=%0d", a, c), r, (c >= dc) ? a : prev_res[sel]);
`ifdef SAR_ONEHOT_CHECK_EN
      chk($sformatf("err a=%h c=%0d", a, c), 4'(sel ? err2 : err0), 4'd0);
`endif
      if (c == extra) set_start(sel, 1'b1);
      if (c == extra + 1) set_start(sel, 1'b0);
      @(posedge clk); #1;
    end
    prev_res[sel] = a;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " trial0"}, trial0, 4'd0);
    chk({nm, " result0"}, result0, 4'd0);
    chk({nm, " busy0"}, 4'(busy0), 4'd0);
    chk({nm, " done0"}, 4'(done0), 4'd0);
    chk({nm, " trial2"}, trial2, 4'd0);
    chk({nm, " result2"}, result2, 4'd0);
`ifdef SAR_ONEHOT_CHECK_EN
    chk({nm, " err0"}, 4'(err0), 4'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    start0 = 1'b0; start2 = 1'b0;
    tgt0 = 4'd0; tgt2 = 4'd0;
    force_en = 1'b0; force_flags = 3'b000;
    prev_res[0] = 4'd0; prev_res[1] = 4'd0;
    #12;
    chk_reset_vals("por");
    @(negedge clk) rst_n = 1'b1;

    run_search(4'b0000, 0, 1'b0, -1);
    chk("a0 t0", tlog[0], 4'b1000);
    chk("a0 t1", tlog[1], 4'b0100);
    chk("a0 t2", tlog[2], 4'b0010);
    chk("a0 t3", tlog[3], 4'b0001);
    chk("a0 done cycle", 4'(done_seen), 4'd4);
    chk("a0 result", result0, 4'b0000);

    run_search(4'b1111, 0, 1'b0, -1);
    chk("aF t1", tlog[1], 4'b1100);
    chk("aF t2", tlog[2], 4'b1110);
    chk("aF t3", tlog[3], 4'b1111);
    chk("aF done cycle", 4'(done_seen), 4'd4);
    chk("aF result", result0, 4'b1111);

    run_search(4'b1000, 0, 1'b0, -1);
    chk("a8 done cycle", 4'(done_seen), 4'd1);
    chk("a8 result", result0, 4'b1000);

    run_search(4'b0101, 2, 1'b1, -1);
    chk("lat2 t2", tlog[2], 4'b1000);
    chk("lat2 t3", tlog[3], 4'b0100);
    chk("lat2 t8", tlog[8], 4'b0110);
    chk("lat2 t11", tlog[11], 4'b0101);
    chk("lat2 done cycle", 4'(done_seen), 4'd12);
    chk("lat2 result", result2, 4'b0101);

    // Reset mid-search must clear everything immediately.
    @(negedge clk);
    tgt0 = 4'b1111;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    chk("pre-reset busy", 4'(busy0), 4'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    prev_res[0] = 4'd0; prev_res[1] = 4'd0;
    @(negedge clk) rst_n = 1'b1;

    run_search(4'b0011, 0, 1'b0, 2);
    chk("a3 result", result0, 4'b0011);

`ifdef SAR_ONEHOT_CHECK_EN
    @(negedge clk);
    force_flags = 3'b011;
    force_en = 1'b1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    chk("oh busy c0", 4'(busy0), 4'd1);
    @(posedge clk); #1;
    chk("oh done", 4'(done0), 4'd1);
    chk("oh err", 4'(err0), 4'd1);
    chk("oh result", result0, 4'd0);
    chk("oh busy", 4'(busy0), 4'd0);
    @(posedge clk); #1;
    chk("oh done clr", 4'(done0), 4'd0);
    chk("oh err held", 4'(err0), 4'd1);
    force_en = 1'b0;
    prev_res[0] = 4'd0;
    run_search(4'b0110, 0, 1'b0, -1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sar_search_4_bits.md
SAR_SEARCH_4_BITS -- requirements
Module: sar_search_4_bits

Interface
REQ-001 SHALL have parameter CMP_LAT, default 0, meaning the number of extra settle cycles after each trial update before the comparator flags are sampled (legal range 0..7).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request a new search; accepted only in IDLE.
REQ-005 SHALL have port cmp_e, input, 1 bit: comparator flag, unknown target A equals trial.
REQ-006 SHALL have port cmp_plus, input, 1 bit: comparator flag, A greater than trial.
REQ-007 SHALL have port cmp_less, input, 1 bit: comparator flag, A less than trial.
REQ-008 SHALL have port trial, output, 4 bits: the value driven to the comparator B input.
REQ-009 SHALL have port result, output, 4 bits: the resolved value of A.
REQ-010 SHALL have port busy, output, 1 bit: high while a search is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when result is valid.
REQ-012 SHALL have port err, output, 1 bit: protocol violation flag (present only per REQ-027).

Function
REQ-013 SHALL implement the FSM states IDLE, TEST and DONE.
- IDLE -> TEST when start=1: trial=1000, bit index=3, settle count=0.
REQ-014 SHALL, in TEST, increment the settle count each cycle and sample the flags at the edge where settle count equals CMP_LAT.
REQ-015 SHALL apply the following at each sample edge:
- cmp_e: result=trial, go to DONE (early termination).
- cmp_less: clear trial[bit].
- cmp_plus: keep trial[bit].
REQ-016 SHALL, after the REQ-015 update with no early termination:
- if bit=0: result=updated trial, go to DONE;
- otherwise: decrement bit, set the new trial[bit]=1, clear the settle count.
REQ-017 SHALL have a worst-case latency, from the start edge to done high, of 4*(CMP_LAT+1) cycles; with CMP_LAT=0 this is 4 cycles.
REQ-018 SHALL hold done high for exactly the one DONE cycle, then return to IDLE.
REQ-019 SHALL hold busy high exactly while in TEST.
REQ-020 SHALL ignore start while in TEST or DONE; no queuing.
REQ-021 SHALL hold trial and result at their last values in IDLE until the next accepted start.
REQ-022 SHALL resolve flags by priority cmp_e > cmp_less > cmp_plus; all-low flags SHALL be treated as cmp_plus.

Reset
REQ-023 SHALL, on rst_n low at any time (including mid-search), immediately force: state=IDLE, trial=0000, result=0000, busy=0, done=0, err=0.
REQ-024 SHALL accept no start until the first clock edge after rst_n deasserts.

Configuration
REQ-025 SHALL provide the macro SAR_ONEHOT_CHECK_EN to compile the flag-integrity check in or out.
REQ-026 SHALL behave as follows when SAR_ONEHOT_CHECK_EN is defined: at a sample edge, if the flags are not exactly one-hot, result=0000, err=1, go to DONE (done pulses); err clears on the next accepted start.
REQ-027 SHALL behave as follows when SAR_ONEHOT_CHECK_EN is undefined: the err port is absent and REQ-022 priority applies unconditionally.

Structure
REQ-028 SHALL place the constant WIDTH=4 and the state enumeration (IDLE, TEST, DONE) in the shared package sar_pkg.
REQ-029 SHALL place the settle counter in one sub-module, sar_settle_timer, with inputs clr and en, parameter CMP_LAT, and output expired.

Verification
REQ-030 SHALL have a bench that connects the DUT to a behavioural 4-bit magnitude comparator with target A, using CMP_LAT=0 unless stated otherwise, and covers the following scenarios:
- A=0000, start -> trial sequence 1000, 0100, 0010, 0001; done at cycle 4; result=0000.
- A=1111, start -> trial sequence 1000, 1100, 1110, 1111; done at cycle 4; result=1111.
- A=1000, start -> cmp_e on the first sample; done at cycle 1; result=1000.
- A=0101 with CMP_LAT=2 -> busy for 12 cycles; done at cycle 12; result=0101; each trial stable for 3 cycles.
- rst_n pulsed low during the second test, then A=0011 and start -> immediate reset values on assertion; the new search yields result=0011; a start asserted while busy=1 is ignored.
- With SAR_ONEHOT_CHECK_EN defined, force cmp_plus=cmp_less=1 on the first sample -> err=1, done pulse, result=0000; the next start clears err.
